hex_emitter: RTL

- Inverse of the hex input path: accepts raw byte values, buffers them in an internal byte FIFO and serialises each byte as ASCII text for a character sink (e.g. UART transmitter).
- Each byte is emitted as two hex digits, high nibble first, then one separator: a space, or a line feed after every BYTES_PER_LINE bytes.
- The output side has a FIFO-style show-ahead interface (empty / pop_front / data_out).

---
 rtl/hex_emitter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hex_emitter.sv
// Byte-to-ASCII hex serialiser: buffers raw bytes in a small FIFO and emits each one
// as two hex digits followed by a space, or by a line feed at the end of each line.
module hex_emitter #(
  parameter int DEPTH          = 16,
  parameter int BYTES_PER_LINE = 16,
  parameter int UPPERCASE      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_back,
  input  logic [7:0] data_in,
  output logic       full,
  input  logic       pop_front,
  output logic [7:0] data_out,
  output logic       empty,
  output logic       error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(BYTES_PER_LINE - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {NONE, HIGH, LOW, SEP} phase_t;

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return ((UPPERCASE != 0) ? 8'h41 : 8'h61) + {4'h0, n - 4'd10};
  endfunction

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  phase_t        phase_q, phase_d;
  logic [7:0]    cur_q, cur_d;
  logic [CW-1:0] col_q, col_d;
  logic          err_q, err_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          push_ok, deq;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    phase_d    = phase_q;
    cur_d      = cur_q;
    col_d      = col_q;
    deq        = 1'b0;
    push_ok    = push_back && !full_q;
    err_d      = err_q | (push_back & full_q);
    data_out_d = 8'h00;

    case (phase_q)
      NONE: begin
        if (pop_front) err_d = 1'b1;
        if (count_q != '0) deq = 1'b1;
      end
      HIGH: if (pop_front) phase_d = LOW;
      LOW:  if (pop_front) phase_d = SEP;
      SEP: begin
        if (pop_front) begin
          col_d = (col_q == LAST_COL) ? '0 : col_q + CW'(1);
          // Reload straight from SEP so a busy stream has no empty bubble.
          if (count_q != '0) deq = 1'b1;
          else               phase_d = NONE;
        end
      end
      default: phase_d = NONE;
    endcase

    if (deq) begin
      cur_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
      phase_d  = HIGH;
    end
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (push_ok && !deq)      count_d = count_q + (AW+1)'(1);
    else if (!push_ok && deq) count_d = count_q - (AW+1)'(1);

    // Outputs are registered from next state so nothing combinational reaches them.
    full_d  = (count_d == FULL_CNT);
    empty_d = (phase_d == NONE);
    case (phase_d)
      HIGH:    data_out_d = hex_digit(cur_d[7:4]);
      LOW:     data_out_d = hex_digit(cur_d[3:0]);
      SEP:     data_out_d = (col_d == LAST_COL) ? 8'h0A : 8'h20;
      default: data_out_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_in;
    cur_q <= cur_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      phase_q    <= NONE;
      col_q      <= '0;
      err_q      <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      data_out_q <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      err_q      <= err_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      data_out_q <= data_out_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign data_out = data_out_q;
  assign error    = err_q;

endmodule
